// File: rtl/regfile_pkg.sv
// Shared sizing constants for the register file and its read-port muxes.
`timescale 1ns/1ps
package regfile_pkg;
    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = $clog2(NREG);

    localparam logic [AW-1:0] REG_ZERO = '0;
endpackage

// File: rtl/mux.sv
// Generic N:1 word multiplexer over a flat bus; word 0 sits in the LSBs.
`timescale 1ns/1ps
module mux #(
    parameter int W  = 32,
    parameter int N  = 32,
    parameter int SW = 5
) (
    input  logic [N*W-1:0] din,
    input  logic [SW-1:0]  sel,
    output logic [W-1:0]   dout
);
    assign dout = din[sel*W +: W];
endmodule

// File: rtl/regfile.sv
// Two-read, one-write register file with hardwired-zero x0 and write-through bypass.
`timescale 1ns/1ps
module regfile #(
    parameter int XLEN = regfile_pkg::XLEN,
    parameter int NREG = regfile_pkg::NREG,
    parameter int AW   = regfile_pkg::AW
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [AW-1:0]   raddr1,
    input  logic [AW-1:0]   raddr2,
    output logic [XLEN-1:0] rdata1,
    output logic [XLEN-1:0] rdata2
);
    import regfile_pkg::*;

    logic [XLEN-1:0]      regs [NREG-1:1];
    logic [NREG-1:1]      wen;
    logic [NREG*XLEN-1:0] flat;
    logic [XLEN-1:0]      mux_out1;
    logic [XLEN-1:0]      mux_out2;
    logic                 wr_live;

    // Index 0 has no enable bit at all, so x0 can never be written.
    always_comb begin
        wen = '0;
        for (int i = 1; i < NREG; i++) begin
            wen[i] = we && (waddr == AW'(i));
        end
    end

    // NOTE: the storage array is reset on purpose so every register reads 0 out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 1; i < NREG; i++) begin
                if (wen[i]) begin
                    regs[i] <= wdata;
                end
            end
        end
    end

    // NOTE: flat gets a full default before the loop so no bit can infer a latch.
    always_comb begin
        flat = '0;
        for (int i = 1; i < NREG; i++) begin
            flat[i*XLEN +: XLEN] = regs[i];
        end
    end

    mux #(.W(XLEN), .N(NREG), .SW(AW)) u_mux1 (
        .din  (flat),
        .sel  (raddr1),
        .dout (mux_out1)
    );

    mux #(.W(XLEN), .N(NREG), .SW(AW)) u_mux2 (
        .din  (flat),
        .sel  (raddr2),
        .dout (mux_out2)
    );

    // Bypass is qualified with rst_n so a write held during reset never leaks out.
    assign wr_live = rst_n && we && (waddr != REG_ZERO);

    assign rdata1 = (wr_live && (raddr1 == waddr)) ? wdata : mux_out1;
    assign rdata2 = (wr_live && (raddr2 == waddr)) ? wdata : mux_out2;
endmodule

// File: doc/regfile.md
REGFILE -- requirements
Module: regfile

Interface
REQ-001 Parameter XLEN, 32, data word width in bits.
REQ-002 Parameter NREG, 32, number of architectural registers.
REQ-003 Parameter AW, 5, register address width; SHALL equal clog2(NREG).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 we  input  1  write enable for the write port.
REQ-007 waddr  input  AW  write register index.
REQ-008 wdata  input  XLEN  write data.
REQ-009 raddr1  input  AW  read port 1 register index.
REQ-010 raddr2  input  AW  read port 2 register index.
REQ-011 rdata1  output  XLEN  read port 1 data.
REQ-012 rdata2  output  XLEN  read port 2 data.

Function
REQ-013 Storage SHALL be NREG words of XLEN bits, x0..x31.
REQ-014 A write SHALL occur on the rising clk edge when we=1 and waddr!=0; x[waddr] takes wdata.
REQ-015 A write with waddr=0 SHALL be discarded; x0 SHALL read 0 at all times.
REQ-016 A cycle with we=0 SHALL leave all registers unchanged.
REQ-017 Read ports SHALL be combinational; rdataN reflects raddrN in the same cycle, zero-cycle latency.
REQ-018 Write-through bypass: if we=1, waddr=raddrN and waddr!=0, rdataN SHALL equal wdata in that cycle, before the edge.
REQ-019 Both read ports SHALL be independent; raddr1=raddr2 SHALL return identical data, including under bypass.
REQ-020 Back-to-back writes to the same index SHALL leave the last value; the intermediate value SHALL be visible in the cycle between the two edges.
REQ-021 Write data SHALL be stored exactly XLEN bits: no sign or zero extension, no truncation.

Reset
REQ-022 While rst_n=0, all registers SHALL be cleared asynchronously to 0, independent of clk.
REQ-023 While rst_n=0, writes SHALL be ignored and bypass suppressed; rdata1=rdata2=0.
REQ-024 Reset asserted in the same cycle as a write SHALL win; the register reads 0 after release.
REQ-025 After rst_n deasserts, the first write SHALL take effect on the first rising edge at which we=1.

Structure
REQ-026 A shared package regfile_pkg SHALL hold XLEN, NREG and AW, plus the zero-register index constant REG_ZERO=0.
REQ-027 Each read port SHALL instantiate the existing module mux (32:1, 32-bit words):
- input: 1024-bit concatenation, x31 in the MSBs, x0 in the LSBs
- select: raddrN
- bypass: a 2:1 select after the mux output
REQ-028 The write decoder (index to one-hot enable, bit 0 forced low) SHALL be inline logic, not a separate module.

Verification
REQ-029 Reset: rst_n=0, then any raddr 0..31 -> rdata1=rdata2=0; release, no writes -> all reads 0.
REQ-030 Write sweep: for i=1..31 write x[i]=i*0x01010101, then read i on both ports -> value matches; x0 reads 0.
REQ-031 x0 write: we=1, waddr=0, wdata=0xDEADBEEF; then raddr1=0 -> rdata1=0, including in the write cycle.
REQ-032 Bypass: x5=0x11111111; drive we=1, waddr=5, wdata=0x22222222, raddr1=raddr2=5 -> both read 0x22222222 before the edge and after it; with we=0 -> 0x11111111 unchanged before the edge.
REQ-033 Async reset mid-operation: x7=0xA5A5A5A5; pulse rst_n low between clock edges during we=1 to waddr=7 -> rdata immediately 0; after release x7 reads 0.
REQ-034 Dual port: x3=3, x4=4; raddr1=3, raddr2=4 -> 3 and 4; swap addresses -> 4 and 3 in the same cycle.
